// File: rtl/rot_feed_ctl_if.sv
// rot_feed_ctl_if: request/result valid-ready bundle for rot_feed_ctl.
// master drives requests and consumes results; slave is the block.
interface rot_feed_ctl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rot_feed_ctl.sv
// rot_feed_ctl: registered front-end + 2-entry result FIFO around rgtshf.
// Optional completed-output counter enabled by defining ROT_CNT_EN.
module rgtshf (
  input  logic [31:0] dt,
  input  logic [4:0]  sv,
  output logic [31:0] out
);
  assign out = (dt >> sv) | (dt << (6'd32 - {1'b0, sv}));
endmodule

module rot_feed_ctl (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  rot_feed_ctl_if.slave bus,
  output logic          busy,
  output logic [15:0]   out_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [4:0]  sv;
  } s1_t;

  s1_t         s1;
  logic [1:0]  cnt;
  logic        wptr;
  logic        rptr;
  logic [31:0] mem [2];
  logic [31:0] rot;
  logic [4:0]  sv_in;
  logic        pop;
  logic        adv;
  logic        acc;

  // left rotate by n == right rotate by (32-n) mod 32
  assign sv_in = bus.in_dir ? (5'd0 - bus.in_amt) : bus.in_amt;

  rgtshf u_rot (
    .dt  (s1.data),
    .sv  (s1.sv),
    .out (rot)
  );

  assign bus.out_valid = (cnt != 2'd0);
  assign bus.out_data  = mem[rptr];
  assign pop           = bus.out_valid & bus.out_ready;
  assign adv           = s1.valid & (~cnt[1] | pop);
  assign bus.in_ready  = ~s1.valid | adv;
  assign acc           = bus.in_valid & bus.in_ready;
  assign busy          = s1.valid | (cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      cnt    <= 2'd0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clr) begin
      s1.valid <= 1'b0;
      cnt      <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
    end else begin
      s1.valid <= acc | (s1.valid & ~adv);
      if (acc) begin
        s1.data <= bus.in_data;
        s1.sv   <= sv_in;
      end
      if (adv) begin
        mem[wptr] <= rot;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      unique case ({adv, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef ROT_CNT_EN
  logic [15:0] cnt_q;

  // survives clr; only rst zeroes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (pop & ~clr)  cnt_q <= cnt_q + 16'd1;
  end

  assign out_cnt = cnt_q;
`else
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_rot_feed_ctl.sv
// tb_rot_feed_ctl: random + directed bench for rot_feed_ctl,
// checked against a queue-based model of the request/result flow.
module tb_rot_feed_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        busy;
  logic [15:0] out_cnt;

  rot_feed_ctl_if bus ();

  rot_feed_ctl dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .bus     (bus),
    .busy    (busy),
    .out_cnt (out_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [31:0] s1q [$];
  logic [31:0] fq  [$];
  logic [15:0] mcnt = '0;
  int          npop = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotm(input logic [31:0] d,
                                       input logic [4:0] n,
                                       input logic dir);
    logic [63:0] w;
    w = {d, d};
    if (dir) begin
      w = w << n;
      return w[63:32];
    end
    w = w >> n;
    return w[31:0];
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d,
                     input logic [4:0] a, input logic dir,
                     input logic ordy, input logic c,
                     output logic acc, output logic dut_rdy);
    logic        pop;
    logic        adv;
    logic        rdy;
    logic [15:0] ecnt;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_dir    = dir;
    bus.out_ready = ordy;
    clr           = c;
    pop = (fq.size() > 0) && ordy;
    adv = (s1q.size() > 0) && ((fq.size() < 2) || pop);
    rdy = (s1q.size() == 0) || adv;
    acc = v && rdy && !c;
`ifdef ROT_CNT_EN
    ecnt = mcnt;
`else
    ecnt = '0;
`endif
    #1;
    dut_rdy = bus.in_ready;
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    check("out_valid", 32'(bus.out_valid), 32'(fq.size() > 0));
    if (fq.size() > 0) check("out_data", bus.out_data, fq[0]);
    check("busy", 32'(busy), 32'((s1q.size() > 0) || (fq.size() > 0)));
    check("out_cnt", 32'(out_cnt), 32'(ecnt));
    @(posedge clk);
    if (c) begin
      s1q.delete();
      fq.delete();
    end else begin
      if (pop) begin
        void'(fq.pop_front());
        mcnt++;
        npop++;
      end
      if (adv) fq.push_back(s1q.pop_front());
      if (v && rdy) s1q.push_back(rotm(d, a, dir));
    end
  endtask

  task automatic idle(input int n);
    logic a, r;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, a, r);
  endtask

  task automatic dir_case(input string tag, input logic [31:0] d,
                          input logic [4:0] a, input logic dir,
                          input logic [31:0] exp);
    logic acc, r;
    cyc(1'b1, d, a, dir, 1'b1, 1'b0, acc, r);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc, r);
    #1;
    check({tag, "_v"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.out_data, exp);
    idle(2);
  endtask

  initial begin
    logic        acc, r, pend;
    logic [31:0] pd;
    logic [4:0]  pa;
    logic        pdir;
    int          stalls, n;
    logic [31:0] bd [4];

    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("rst_irdy", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_odata", bus.out_data, 32'd0);
    check("rst_cnt", 32'(out_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    dir_case("rr1", 32'h8000_0001, 5'd1, 1'b0, 32'hC000_0000);
    dir_case("rl4", 32'h0000_0001, 5'd4, 1'b1, 32'h0000_0010);
    dir_case("rl0", 32'h1234_5678, 5'd0, 1'b1, 32'h1234_5678);
    dir_case("rr16", 32'hAAAA_5555, 5'd16, 1'b0, 32'h5555_AAAA);

    // backpressure: 3 fit, the 4th waits
    for (int i = 0; i < 4; i++) bd[i] = $urandom;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, bd[i], 5'(i + 3), i[0], 1'b0, 1'b0, acc, r);
    cyc(1'b1, bd[3], 5'd9, 1'b1, 1'b0, 1'b0, acc, r);
    check("bp_rdy4", 32'(r), 32'd0);
    n = 0;
    do begin
      cyc(1'b1, bd[3], 5'd9, 1'b1, 1'b1, 1'b0, acc, r);
      n++;
    end while (!acc && n < 20);
    check("bp_acc_to", 32'(acc), 32'd1);
    idle(6);
    #1;
    check("bp_busy", 32'(busy), 32'd0);

    // full throughput
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0, acc, r);
      if (!r) stalls++;
    end
    check("tp_stalls", 32'(stalls), 32'd0);
    idle(3);

    // mixed random traffic with held requests and occasional flush
    pend = 1'b0;
    pd = '0;
    pa = '0;
    pdir = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!pend && ($urandom_range(0, 9) < 7)) begin
        pend = 1'b1;
        pd   = $urandom;
        pa   = 5'($urandom);
        pdir = 1'($urandom);
      end
      cyc(pend, pd, pa, pdir, 1'($urandom_range(0, 2) != 0),
          ($urandom_range(0, 39) == 0), acc, r);
      if (acc) pend = 1'b0;
    end
    idle(4);

    // flush with FIFO full and S1 occupied
    for (int i = 0; i < 3; i++)
      cyc(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, acc, r);
    cyc(1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 1'b1, acc, r);
    check("clr_irdy", 32'(r), 32'd1);
    #1;
    check("clr_ovalid", 32'(bus.out_valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    idle(2);

    // async reset mid-stream
    for (int i = 0; i < 3; i++)
      cyc(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, acc, r);
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_ovalid", 32'(bus.out_valid), 32'd0);
    check("arst_irdy", 32'(bus.in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_odata", bus.out_data, 32'd0);
    check("arst_cnt", 32'(out_cnt), 32'd0);
    s1q.delete();
    fq.delete();
    mcnt = '0;
    npop = 0;
    @(negedge clk);
    rst = 1'b0;

`ifdef ROT_CNT_EN
    n = 0;
    while (npop < 65537 && n < 70000) begin
      cyc(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0, acc, r);
      n++;
    end
    check("cnt_pops", 32'(npop), 32'd65537);
    #1;
    check("cnt_wrap", 32'(out_cnt), 32'd1);
`else
    for (int i = 0; i < 50; i++)
      cyc(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0, acc, r);
    #1;
    check("cnt_off", 32'(out_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/rot_feed_ctl.md
# rot_feed_ctl

Streaming front-end for the team's 32-bit combinational right-rotator `rgtshf` (ports `dt[31:0]`, `sv[4:0]`, `out[31:0]`). The block accepts rotate requests over a valid/ready handshake and registers each operand. It converts left-rotate requests to the equivalent right-rotate amount, drives one internal `rgtshf` instance from that register, and captures the rotator output into a 2-entry output FIFO. It decouples the rotator from upstream and downstream stalls and sustains one rotation per cycle.

## Interface
- No parameters; data width fixed at 32, amount width fixed at 5.
- Reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `clr`  in  1  synchronous flush of all held entries
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept a request this cycle
- `in_data`  in  32  word to rotate
- `in_amt`  in  5  rotate amount, 0–31
- `in_dir`  in  1  0 = rotate right, 1 = rotate left
- `out_valid`  out  1  FIFO head holds a result
- `out_ready`  in  1  downstream consumes the head
- `out_data`  out  32  rotated word at FIFO head
- `busy`  out  1  S1 or FIFO holds an entry
- `out_cnt`  out  16  completed-output counter (see Configuration)

## Operation
- Stage S1 is a register holding `s1_valid`, `s1_data` and `s1_sv`.
- `s1_sv` is `in_amt` when `in_dir`=0, and `(32 - in_amt) mod 32` when `in_dir`=1, computed in 5 bits. A left rotate by 0 gives 0.
- `rgtshf` is driven by `dt=s1_data` and `sv=s1_sv`. Its output is combinational into the FIFO write port.
- The FIFO has 2 entries, a 2-bit count (0–2), 1-bit read/write pointers that wrap, and registered storage.
- pop = `out_valid & out_ready`.
- S1 advances (FIFO write) when `s1_valid & (count<2 | pop)`.
- `in_ready = ~s1_valid | advance`. Acceptance is `in_valid & in_ready`; the accepted request loads S1.
- Simultaneous pop and write with count=2 is legal: count stays 2 and both pointers move.
- Simultaneous pop and write with count=0 cannot occur (`out_valid`=0).
- `out_valid = (count != 0)`. `out_data` is the head entry and is held stable while `out_valid & ~out_ready`.
- `busy = s1_valid | (count != 0)`.
- `clr`:
  - Next edge forces `s1_valid`=0, count=0 and both pointers to 0.
  - Takes priority over acceptance, advance and pop in the same cycle; none of them take effect and `out_cnt` does not increment.
  - `in_ready` is unaffected combinationally.

## Timing
- Reset values: `s1_valid`=0, count=0, pointers=0, `out_valid`=0, `in_ready`=1, `busy`=0, `out_data`=0, `out_cnt`=0.
- Reset mid-operation discards all entries immediately and asynchronously.
- Latency: a request accepted at edge k, with no stall, is written to the FIFO at edge k+1. `out_valid` is visible after edge k+1.
- Throughput: 1 request per cycle while `out_ready`=1.
- Capacity under full stall (`out_ready`=0): 3 requests, 2 in the FIFO and 1 in S1. `in_ready` then drops combinationally.
- Ordering is strict FIFO; no reordering and no drops.

## Configuration
- `ROT_CNT_EN` defined:
  - `out_cnt` increments by 1 on every pop.
  - It wraps from 0xFFFF to 0x0000.
  - It is cleared only by `rst`; `clr` does not clear it.
- `ROT_CNT_EN` undefined: `out_cnt` is driven constant 0 and the counter register is not synthesized.

## Test plan
- Right rotate: `in_data`=0x80000001, `in_amt`=1, `in_dir`=0, `out_ready`=1 → `out_data`=0xC0000000, `out_valid` 2 edges after the request is presented.
- Left rotate: 0x00000001 by 4 → 0x00000010 (S1 `sv`=28). Left rotate 0x12345678 by 0 → 0x12345678. Right rotate by 16 of 0xAAAA5555 → 0x5555AAAA.
- Backpressure: `out_ready`=0, present 4 back-to-back requests → 3 accepted, `in_ready`=0 on the 4th. Raise `out_ready` → all 4 emerge in order, then `busy`=0.
- Full throughput: `out_ready`=1, 100 random requests in consecutive cycles → `in_ready` stays 1 and every output matches the model's rotate.
- Flush and reset:
  - `clr` pulsed with count=2 and S1 full → next cycle `out_valid`=0, `busy`=0.
  - `rst` asserted mid-stream between edges → outputs reach reset values immediately.
- Counter (`ROT_CNT_EN`): 65537 pops → `out_cnt`=1. Without the macro, `out_cnt` stays 0 throughout.
